// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared types and constants for the show-ahead async FIFO read-side stream
// adapter (async_fifo_show_ahead_rd_stream) and its skid buffer.
//   rd_stream_state_t : adapter state (RUN / FLUSH)
//   STAT_WIDTH        : width of the optional statistics counters
//   SKID_DEPTH        : number of entries in the read-side skid buffer
// -----------------------------------------------------------------------------
package async_fifo_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rd_stream_state_t;

  localparam int STAT_WIDTH = 32;
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/async_fifo_show_ahead_rd_stream_if.sv
// -----------------------------------------------------------------------------
// async_fifo_show_ahead_rd_stream_if
// Bundles the FIFO read-side signals and the outgoing valid/ready stream.
//   rdreq    : pop request to the FIFO read logic
//   rdempty  : FIFO empty flag (registered at its source)
//   q        : FIFO head word, valid while rdempty = 0
//   rdusedw  : FIFO read-side used-word count
//   m_valid  : stream data valid
//   m_ready  : stream sink ready
//   m_data   : stream data
// Modports:
//   master : the adapter (drives rdreq and the stream outputs)
//   slave  : the environment (FIFO read logic + stream sink)
// -----------------------------------------------------------------------------
interface async_fifo_show_ahead_rd_stream_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_ADDR_WIDTH = 8
);

  logic                       rdreq;
  logic                       rdempty;
  logic [DATA_WIDTH-1:0]      q;
  logic [FIFO_ADDR_WIDTH-1:0] rdusedw;
  logic                       m_valid;
  logic                       m_ready;
  logic [DATA_WIDTH-1:0]      m_data;

  modport master (
    output rdreq,
    input  rdempty,
    input  q,
    input  rdusedw,
    output m_valid,
    input  m_ready,
    output m_data
  );

  modport slave (
    input  rdreq,
    output rdempty,
    output q,
    output rdusedw,
    input  m_valid,
    output m_ready,
    input  m_data
  );

endinterface

// File: rtl/async_fifo_rd_skid_buf.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_skid_buf
// In-order 2-entry register buffer sitting between the FIFO head and the
// stream output. Entry 0 is always the head.
// Ports:
//   rdclk  in  : clock
//   reset  in  : synchronous active-high reset (empties, zeroes the entries)
//   push   in  : write din into the tail
//   din    in  : data to write
//   pop    in  : remove the head entry
//   clear  in  : discard all entries (wins over push/pop for the count)
//   cnt    out : occupancy, 0..SKID_DEPTH
//   head   out : head entry
// -----------------------------------------------------------------------------
module async_fifo_rd_skid_buf
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rdclk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  input  logic                  clear,
  output logic [1:0]            cnt,
  output logic [DATA_WIDTH-1:0] head
);

  logic [1:0]            cnt_reg;
  logic [DATA_WIDTH-1:0] entry_reg [SKID_DEPTH];
  logic [1:0]            wr_idx;
  logic [SKID_DEPTH-1:0] wr_sel;

  // With a simultaneous pop the surviving entries shift down by one, so the
  // tail slot for the incoming word is one lower.
  assign wr_idx = pop ? (cnt_reg - 2'd1) : cnt_reg;

  generate
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = push && (wr_idx == 2'(gi));
    end
  endgenerate

  always_ff @(posedge rdclk) begin
    if (reset) begin
      cnt_reg      <= 2'd0;
      entry_reg[0] <= '0;
      entry_reg[1] <= '0;
    end else begin
      if (clear) begin
        cnt_reg <= 2'd0;
      end else begin
        cnt_reg <= cnt_reg + 2'(push) - 2'(pop);
      end

      if (wr_sel[0]) begin
        entry_reg[0] <= din;
      end else if (pop) begin
        entry_reg[0] <= entry_reg[1];
      end

      if (wr_sel[1]) begin
        entry_reg[1] <= din;
      end
    end
  end

  assign cnt  = cnt_reg;
  assign head = entry_reg[0];

endmodule

// File: rtl/async_fifo_show_ahead_rd_stream.sv
// -----------------------------------------------------------------------------
// async_fifo_show_ahead_rd_stream
// Converts the show-ahead FIFO read interface (rdreq/rdempty/q) into a
// valid/ready stream through a 2-entry skid buffer, so m_ready never reaches
// rdreq combinationally. Also reports a combined fill level and implements a
// flush state machine that drains and discards the FIFO contents.
// Ports:
//   rdclk      in  : clock (only clock)
//   reset      in  : synchronous active-high reset
//   bus        if  : async_fifo_show_ahead_rd_stream_if.master
//                    (rdreq, rdempty, q, rdusedw, m_valid, m_ready, m_data)
//   level      out : registered rdusedw + skid occupancy, FIFO_ADDR_WIDTH+1 bits
//   flush      in  : single-cycle drain-and-discard request
//   flush_done out : one-cycle pulse when the drain completes
// Optional (macro ASYNC_FIFO_STREAM_STATS_EN):
//   stat_beats   out : count of stream transfers (wraps)
//   stat_dropped out : skid entries discarded on flush + words popped in FLUSH
// -----------------------------------------------------------------------------
module async_fifo_show_ahead_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_ADDR_WIDTH = 8
) (
  input  logic                                 rdclk,
  input  logic                                 reset,
  async_fifo_show_ahead_rd_stream_if.master    bus,
  output logic [FIFO_ADDR_WIDTH:0]             level,
  input  logic                                 flush,
  output logic                                 flush_done
`ifdef ASYNC_FIFO_STREAM_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]                stat_beats,
  output logic [STAT_WIDTH-1:0]                stat_dropped
`endif
);

  localparam int LEVEL_WIDTH = FIFO_ADDR_WIDTH + 1;

  rd_stream_state_t         state_reg, state_next;
  logic                     flush_done_reg;
  logic [LEVEL_WIDTH-1:0]   level_reg;

  logic                     rdreq_next;
  logic                     push_next;
  logic                     clear_next;
  logic                     m_valid_next;
  logic                     transfer;
  logic [1:0]               cnt;
  logic [DATA_WIDTH-1:0]    head;

  async_fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .rdclk (rdclk),
    .reset (reset),
    .push  (push_next),
    .din   (bus.q),
    .pop   (transfer),
    .clear (clear_next),
    .cnt   (cnt),
    .head  (head)
  );

  always_ff @(posedge rdclk) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // The pop decision uses only registered terms (cnt, rdempty, state) plus
  // flush, which keeps m_ready out of the rdreq path.
  always_comb begin
    state_next   = state_reg;
    rdreq_next   = 1'b0;
    push_next    = 1'b0;
    clear_next   = 1'b0;
    m_valid_next = 1'b0;
    case (state_reg)
      RUN: begin
        m_valid_next = (cnt != 2'd0);
        rdreq_next   = ~bus.rdempty && (cnt < 2'(SKID_DEPTH)) && ~flush;
        push_next    = rdreq_next;
        if (flush) begin
          // This cycle's handshake still completes; whatever remains is dropped.
          state_next = FLUSH;
          clear_next = 1'b1;
        end
      end
      FLUSH: begin
        // Drain the FIFO, discarding every popped word.
        rdreq_next = ~bus.rdempty;
        if (bus.rdempty) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
    if (reset) begin
      rdreq_next = 1'b0;
      push_next  = 1'b0;
    end
  end

  assign transfer = m_valid_next && bus.m_ready;

  always_ff @(posedge rdclk) begin
    if (reset) begin
      flush_done_reg <= 1'b0;
      level_reg      <= '0;
    end else begin
      flush_done_reg <= (state_reg == FLUSH) && bus.rdempty;
      level_reg      <= {1'b0, bus.rdusedw} + LEVEL_WIDTH'(cnt);
    end
  end

`ifdef ASYNC_FIFO_STREAM_STATS_EN
  logic [STAT_WIDTH-1:0] stat_beats_reg;
  logic [STAT_WIDTH-1:0] stat_dropped_reg;
  logic [1:0]            drop_inc;

  // Entries left behind by the flush-entry transfer, or the discarded pop.
  always_comb begin
    drop_inc = 2'd0;
    if (state_reg == RUN && flush) begin
      drop_inc = cnt - 2'(transfer);
    end else if (state_reg == FLUSH) begin
      drop_inc = 2'(rdreq_next);
    end
  end

  always_ff @(posedge rdclk) begin
    if (reset) begin
      stat_beats_reg   <= '0;
      stat_dropped_reg <= '0;
    end else begin
      stat_beats_reg   <= stat_beats_reg + STAT_WIDTH'(transfer);
      stat_dropped_reg <= stat_dropped_reg + STAT_WIDTH'(drop_inc);
    end
  end

  assign stat_beats   = stat_beats_reg;
  assign stat_dropped = stat_dropped_reg;
`endif

  assign bus.rdreq   = rdreq_next;
  assign bus.m_valid = m_valid_next;
  assign bus.m_data  = head;
  assign level       = level_reg;
  assign flush_done  = flush_done_reg;

endmodule

// File: doc/async_fifo_show_ahead_rd_stream.md
# async_fifo_show_ahead_rd_stream

Read-domain adapter that sits directly downstream of the show-ahead async FIFO read logic. It converts the FIFO's show-ahead `rdreq`/`rdempty`/`q` interface into a valid/ready stream, with a 2-entry skid buffer so that `m_ready` never reaches `rdreq` combinationally. It also provides a combined fill level and a flush state machine that drains and discards FIFO contents.

## Interface
- `DATA_WIDTH`, 8: FIFO word and stream data width.
- `FIFO_ADDR_WIDTH`, 8: width of the FIFO `rdusedw` count.
- `rdclk`  in  1: read-domain clock; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `rdreq`  out  1: pop request to the FIFO read logic.
- `rdempty`  in  1: FIFO empty flag, registered at its source.
- `q`  in  DATA_WIDTH: FIFO head word, valid whenever `rdempty`=0.
- `rdusedw`  in  FIFO_ADDR_WIDTH: FIFO read-side used-word count.
- `m_valid`  out  1: stream data valid.
- `m_ready`  in  1: stream sink ready.
- `m_data`  out  DATA_WIDTH: stream data.
- `level`  out  FIFO_ADDR_WIDTH+1: registered `rdusedw` + skid occupancy.
- `flush`  in  1: single-cycle request to drain and discard.
- `flush_done`  out  1: one-cycle pulse when the drain completes.

## Operation
- States: RUN and FLUSH. Reset enters RUN.
- RUN pop rule: `rdreq` = ~`rdempty` & (`cnt` < 2) & ~`flush`. `cnt` is the registered skid occupancy, 0..2.
- The pop rule is built only from registered terms and `flush`. There is no path from `m_ready` to `rdreq`.
- On a pop, `q` is written into the skid tail at the same edge.
- The skid is an in-order 2-entry buffer. `m_valid` = (`cnt`≠0). `m_data` = head entry.
- Transfer occurs when `m_valid` & `m_ready`.
- `cnt` next value = `cnt` + pop − transfer. A pop and a transfer in the same cycle leave `cnt` unchanged.
- RUN→FLUSH on an edge where `flush`=1.
  - The handshake in that cycle still completes.
  - All remaining skid entries are discarded and `cnt` becomes 0.
- FLUSH behaviour:
  - `m_valid`=0.
  - `rdreq` = ~`rdempty`; popped words are discarded.
  - `flush` is ignored.
- FLUSH→RUN on the first edge where `rdempty`=1 is sampled. `flush_done`=1 for the following cycle.
- `level` is registered each cycle as zero-extend(`rdusedw`) + `cnt`. It is FIFO_ADDR_WIDTH+1 bits wide and never wraps.
- Words written into the FIFO after the drain completes are kept and delivered normally in RUN.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `rdreq`=0, `level`=0, `flush_done`=0, state RUN, `cnt`=0.
- `rdreq` is forced to 0 while `reset`=1.
- Latency: head word present with `rdempty`=0 at cycle N and `cnt`=0 → `rdreq`=1 at N, `m_valid`=1 at N+1.
- Throughput: one word per cycle is sustained at `cnt`=1 while `m_ready`=1 and the FIFO stays non-empty.
- `m_ready` low: the skid fills to 2 and then `rdreq` deasserts. Once `cnt` returns below 2, `rdreq` reasserts in the cycle after the transfer edge.
- `m_valid` does not drop while a word is pending. `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- Reset mid-operation: buffered words are lost and the FIFO contents are untouched. The first `rdreq` can occur in the first cycle after `reset` falls.
- Flush with `rdempty`=1 already: FLUSH lasts one cycle and `flush_done` pulses 2 cycles after `flush`.

## Configuration
- Macro `ASYNC_FIFO_STREAM_STATS_EN`.
- Defined: adds two 32-bit output ports, both reset to 0 and wrapping modulo 2^32.
  - `stat_beats`: counts transfers.
  - `stat_dropped`: counts skid entries discarded on flush plus words popped in FLUSH.
- Undefined: both ports and their counters are absent. The remaining behaviour is identical.

## Structure
- Package `async_fifo_pkg`:
  - state enum `rd_stream_state_t` {RUN, FLUSH};
  - constant `STAT_WIDTH`=32;
  - constant `SKID_DEPTH`=2.
- Sub-module `async_fifo_rd_skid_buf`:
  - 2-entry register buffer with push/pop/clear and `cnt` output;
  - the top level holds the FSM, the `level` adder and the stats.

## Test plan
- Reset, then FIFO model holding 0x11, 0x22, 0x33 with `m_ready`=1 → `m_data` shows 0x11, 0x22, 0x33 on consecutive cycles; first `m_valid` 1 cycle after the first `rdreq`.
- `m_ready`=0 with 5 words queued → exactly 2 pops, `rdreq` then 0. `m_ready`=1 → order preserved and no gap once streaming.
- `rdusedw`=255, `cnt`=2 → `level`=257 the next cycle, with no wrap.
- `flush` with `cnt`=2 and 3 words in the FIFO → `m_valid` 0 and 3 discarded pops; `flush_done` pulses once; `stat_dropped`=5 with the macro defined.
- `flush` asserted while already empty → `flush_done` 2 cycles later, then a later write of 0xAA is delivered.
- `reset` asserted while `cnt`=2 → next cycle `m_valid`=0 and `level`=0; FIFO words are then delivered after reset.
